multi_cycle_ctrl: RTL
=====================

Name: multi_cycle_ctrl

Overview:
Moore/Mealy control FSM that sequences a multi-cycle version of the CPU datapath. The datapath has one shared memory port, plus IR, MDR, A/B and ALUOut registers. The block issues per-cycle strobes to PC, IR, register file, memory and the ALU/PC-source muxes, and stalls on a memory-ready handshake. It also counts retired instructions and traps on illegal opcodes.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk_i  in  1  clock; all state changes on rising edge
rst_i  in  1  synchronous reset, active-high
instr_op_i  in  6  IR[31:26]
funct_i  in  6  IR[5:0]
zero_i  in  1  ALU zero flag (current cycle)
mem_ready_i  in  1  memory completes the current access this cycle
pc_write_o  out  1  load PC
ir_write_o  out  1  load IR (and MDR capture is unconditional in datapath)
i_or_d_o  out  1  memory address: 0=PC, 1=ALUOut
mem_read_o  out  1  memory read request
mem_write_o  out  1  memory write request
reg_write_o  out  1  register file write
reg_dst_o  out  2  0=rt, 1=rd, 2=r31
mem_to_reg_o  out  2  0=ALUOut, 1=MDR, 2=PC
alu_src_a_o  out  1  0=PC, 1=A
alu_src_b_o  out  2  0=B, 1=const 4, 2=sext imm, 3=sext imm<<2
alu_op_o  out  3  0=ADD, 1=SUB, 2=RTYPE(funct), 3=SLT, 4=OR
pc_source_o  out  2  0=ALU result, 1=ALUOut, 2={PC[31:28],IR[25:0],2'b00}, 3=A (rs)
state_o  out  4  current state encoding (debug)
illegal_o  out  1  sticky trap flag
retired_o  out  CNT_W  retired-instruction count

Behaviour:
- Opcodes: R=0, j=2, jal=3, beq=4, bne=5, addi=8, slti=10, ori=13, lw=35, sw=43. jr is R-type with funct=8.
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, ALU_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, JAL=11, JR=12, TRAP=15.
- Unlisted outputs are 0 in every state.
- Reset:
  - While rst_i=1, every strobe output is 0 and the state becomes FETCH on the next edge.
  - retired_o and illegal_o clear to 0.
  - Reset mid-access abandons the access; no write strobe is asserted in the reset cycle.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_source=0.
  - pc_write and ir_write equal mem_ready_i.
  - Go to DECODE when mem_ready_i=1, else stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=3, ADD (branch target into ALUOut). Next state by opcode:
  - lw/sw -> MEM_ADDR
  - R with funct=8 -> JR; other R -> R_EXEC
  - beq/bne -> BRANCH
  - j -> JUMP; jal -> JAL
  - addi/slti/ori -> I_EXEC
  - any other opcode -> TRAP
- MEM_ADDR: alu_src_a=1, alu_src_b=2, ADD. Go to MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_read=1, i_or_d=1. Hold until mem_ready_i, then go to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Retire; go to FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Hold until mem_ready_i; then retire and go to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=0, alu_op=RTYPE. Go to ALU_WB with reg_dst=1.
- I_EXEC: alu_src_a=1, alu_src_b=2, alu_op = ADD (addi) / SLT (slti) / OR (ori). Go to ALU_WB with reg_dst=0.
  - ALU_WB's reg_dst is taken from a 1-bit registered flag.
- ALU_WB: reg_write=1, mem_to_reg=0. Retire; go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, SUB, pc_source=1.
  - pc_write = zero_i for beq, !zero_i for bne.
  - Retire; go to FETCH.
- JUMP: pc_write=1, pc_source=2. Retire; go to FETCH.
- JAL: pc_write=1, pc_source=2, reg_write=1, reg_dst=2, mem_to_reg=2 (PC already holds PC+4). Retire; go to FETCH.
- JR: pc_write=1, pc_source=3. Retire; go to FETCH.
- TRAP: illegal_o=1, all strobes 0. Absorbing until reset.
- Latency with zero-wait memory: R/addi/slti/ori 4 cycles, lw 5, sw 4, beq/bne/j/jal/jr 3. Each memory wait cycle adds 1.
- mem_ready_i is ignored in states without mem_read/mem_write.
- retired_o increments by 1 in each retiring cycle. It wraps modulo 2^CNT_W and never increments in TRAP.

Decomposition:
- Package mcc_pkg holds:
  - opcode/funct constants
  - state enum (4-bit)
  - ALU-op, reg_dst, mem_to_reg, alu_src_b and pc_source encodings
- Sub-module multi_cycle_ctrl_decode: combinational opcode/funct -> next-state-after-DECODE, I_EXEC alu_op, illegal flag.
- Top holds the state register, output logic and counter.

Test Plan:
- Reset held 2 cycles, then add (op 0, funct 32) with mem_ready=1 -> states 0,1,6,7,0; reg_write=1 only in state 7 with reg_dst=1; retired_o=1.
- lw with mem_ready=0 for 2 cycles in MEM_RD -> states 0,1,2,3,3,3,4; mem_read held 3 cycles; reg_write with mem_to_reg=1; 7 cycles total.
- beq with zero=1, then bne with zero=1 -> beq: pc_write=1, pc_source=1 in BRANCH; bne: pc_write=0; retired_o=2.
- jal then jr (op 0, funct 8) -> JAL: reg_dst=2, mem_to_reg=2, pc_source=2; JR: pc_source=3; each 3 cycles.
- Opcode 6'h3F -> TRAP after DECODE; illegal_o=1; no strobes for 20 cycles; retired_o frozen; rst_i clears it.
- rst_i asserted during MEM_WR with mem_ready=0 -> mem_write=0 in reset cycle; state_o=0 next cycle; retired_o=0.

Source files
------------

// File: rtl/mcc_pkg.sv
// mcc_pkg: opcodes, state encoding and datapath select encodings for multi_cycle_ctrl
package mcc_pkg;
  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_JAL  = 6'd3;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_BNE  = 6'd5;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_SLTI = 6'd10;
  localparam logic [5:0] OP_ORI  = 6'd13;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;
  localparam logic [5:0] FN_JR   = 6'd8;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_ALU_WB   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_JAL      = 4'd11,
    S_JR       = 4'd12,
    S_TRAP     = 4'd15
  } state_e;
  typedef enum logic [2:0] {ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_RTYPE = 3'd2, ALU_SLT = 3'd3, ALU_OR = 3'd4} alu_op_e;
  typedef enum logic [1:0] {DST_RT = 2'd0, DST_RD = 2'd1, DST_R31 = 2'd2} reg_dst_e;
  typedef enum logic [1:0] {M2R_ALU = 2'd0, M2R_MDR = 2'd1, M2R_PC = 2'd2} mem_to_reg_e;
  typedef enum logic [1:0] {SRCB_B = 2'd0, SRCB_4 = 2'd1, SRCB_IMM = 2'd2, SRCB_IMM_SH = 2'd3} alu_src_b_e;
  typedef enum logic [1:0] {PCS_ALU = 2'd0, PCS_ALUOUT = 2'd1, PCS_JUMP = 2'd2, PCS_RS = 2'd3} pc_source_e;
endpackage

// File: rtl/multi_cycle_ctrl_decode.sv
// multi_cycle_ctrl_decode: opcode/funct to post-DECODE state, I-type ALU op and illegal flag
module multi_cycle_ctrl_decode
  import mcc_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output state_e     next_o,
  output alu_op_e    i_alu_op_o,
  output logic       illegal_o
);
  always_comb begin
    next_o = S_TRAP;
    illegal_o = 1'b0;
    case (op_i)
      OP_R:                next_o = (funct_i == FN_JR) ? S_JR : S_R_EXEC;
      OP_J:                next_o = S_JUMP;
      OP_JAL:              next_o = S_JAL;
      OP_BEQ, OP_BNE:      next_o = S_BRANCH;
      OP_ADDI, OP_SLTI,
      OP_ORI:              next_o = S_I_EXEC;
      OP_LW, OP_SW:        next_o = S_MEM_ADDR;
      default:             illegal_o = 1'b1;
    endcase
    i_alu_op_o = (op_i == OP_SLTI) ? ALU_SLT : (op_i == OP_ORI) ? ALU_OR : ALU_ADD;
  end
endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: multi-cycle CPU control FSM with memory stall, retire counter and illegal-opcode trap
module multi_cycle_ctrl
  import mcc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       instr_op_i,
  input  logic [5:0]       funct_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             ir_write_o,
  output logic             i_or_d_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             reg_write_o,
  output logic [1:0]       reg_dst_o,
  output logic [1:0]       mem_to_reg_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [2:0]       alu_op_o,
  output logic [1:0]       pc_source_o,
  output logic [3:0]       state_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] retired_o
);
  state_e           state_q, state_d;
  logic             rd_flag_q, rd_flag_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;
  state_e           dec_next;
  alu_op_e          dec_alu_op;
  logic             dec_illegal;

  multi_cycle_ctrl_decode u_decode (
    .op_i       (instr_op_i),
    .funct_i    (funct_i),
    .next_o     (dec_next),
    .i_alu_op_o (dec_alu_op),
    .illegal_o  (dec_illegal)
  );

  always_comb begin
    {pc_write_o, ir_write_o, i_or_d_o, mem_read_o, mem_write_o, reg_write_o} = '0;
    reg_dst_o = DST_RT;
    mem_to_reg_o = M2R_ALU;
    alu_src_a_o = 1'b0;
    alu_src_b_o = SRCB_B;
    alu_op_o = ALU_ADD;
    pc_source_o = PCS_ALU;
    state_d = state_q;
    rd_flag_d = rd_flag_q;
    retire = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_o = 1'b1;
        alu_src_b_o = SRCB_4;
        pc_write_o = mem_ready_i;
        ir_write_o = mem_ready_i;
        state_d = mem_ready_i ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b_o = SRCB_IMM_SH;
        state_d = dec_illegal ? S_TRAP : dec_next;
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        state_d = (instr_op_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read_o = 1'b1;
        i_or_d_o = 1'b1;
        state_d = mem_ready_i ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WB: begin
        reg_write_o = 1'b1;
        mem_to_reg_o = M2R_MDR;
        retire = 1'b1;
        state_d = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write_o = 1'b1;
        i_or_d_o = 1'b1;
        retire = mem_ready_i;
        state_d = mem_ready_i ? S_FETCH : S_MEM_WR;
      end
      S_R_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_op_o = ALU_RTYPE;
        rd_flag_d = 1'b1;
        state_d = S_ALU_WB;
      end
      S_I_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        alu_op_o = dec_alu_op;
        rd_flag_d = 1'b0;
        state_d = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o = rd_flag_q ? DST_RD : DST_RT;
        retire = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o = ALU_SUB;
        pc_source_o = PCS_ALUOUT;
        pc_write_o = (instr_op_i == OP_BNE) ? !zero_i : zero_i;
        retire = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_write_o = 1'b1;
        pc_source_o = PCS_JUMP;
        retire = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        pc_write_o = 1'b1;
        pc_source_o = PCS_JUMP;
        reg_write_o = 1'b1;
        reg_dst_o = DST_R31;
        mem_to_reg_o = M2R_PC;
        retire = 1'b1;
        state_d = S_FETCH;
      end
      S_JR: begin
        pc_write_o = 1'b1;
        pc_source_o = PCS_RS;
        retire = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    // reset cycle abandons any access in flight: no strobe may escape
    if (rst_i) begin
      {pc_write_o, ir_write_o, i_or_d_o, mem_read_o, mem_write_o, reg_write_o} = '0;
      {reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o, pc_source_o} = '0;
      retire = 1'b0;
    end
    retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      rd_flag_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      rd_flag_q <= rd_flag_d;
      retired_q <= retired_d;
    end
  end

  assign state_o = state_q;
  assign illegal_o = (state_q == S_TRAP);
  assign retired_o = retired_q;
endmodule
